// File: rtl/rv_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_muldiv_pkg
// Description : Shared RV32M definitions for the iterative multiply/divide
//               unit and the core decoder. Holds the funct3 encodings, the
//               unit's state encoding and small funct3 decode helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package rv_muldiv_pkg;

  // RV32M funct3 encodings
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // rs1 is a signed operand for MULH, MULHSU, DIV and REM
  function automatic logic f3_rs1_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is a signed operand for MULH, DIV and REM
  function automatic logic f3_rs2_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : rv_muldiv_if
// Description : Request/response bundle between the execute stage (master)
//               and the multiply/divide unit (slave).
// Signals     : start, funct3, rs1_val, rs2_val, rd_in, kill  (master -> slave)
//               ready, done, result, rd_out                  (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface rv_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_in;
  logic            kill;
  logic            ready;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, funct3, rs1_val, rs2_val, rd_in, kill,
    input  ready, done, result, rd_out
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, rd_in, kill,
    output ready, done, result, rd_out
  );
endinterface
`default_nettype wire

// File: rtl/rv_muldiv_div_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_div_step
// Description : One combinational restoring-division step. Shifts the next
//               dividend bit into the partial remainder, trial-subtracts the
//               divisor and keeps the difference when it is non-negative.
// Ports       : rem_i          partial remainder (always < divisor)
//               dividend_bit_i next dividend bit, MSB first
//               divisor_i      divisor magnitude (non-zero)
//               rem_o          next partial remainder
//               q_o            quotient bit produced by this step
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            dividend_bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);

  // XLEN+1 bits: the shifted remainder can reach 2*divisor-1
  logic [XLEN:0] w_partial;
  logic [XLEN:0] w_diff;

  assign w_partial = {rem_i, dividend_bit_i};
  assign w_diff    = w_partial - {1'b0, divisor_i};

  // Borrow out of the trial subtraction means the divisor did not fit
  assign q_o   = ~w_diff[XLEN];
  assign rem_o = q_o ? w_diff[XLEN-1:0] : w_partial[XLEN-1:0];

endmodule
`default_nettype wire

// File: rtl/rv_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : rv_muldiv
// Description : Iterative RV32M multiply/divide unit. Magnitude shift-add
//               multiply (MUL_STEP bits/cycle) and restoring divide (1 bit/
//               cycle), followed by a sign-fix cycle and a registered
//               one-cycle done strobe. Divide-by-zero and signed overflow
//               bypass the iterations.
// Ports       : clk  clock
//               rst  synchronous active-high reset
//               bus  rv_muldiv_if.slave (request, kill, ready/done/result/tag)
// Revision    : 1.0 - initial release
// ============================================================================
module rv_muldiv
  import rv_muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic       clk,
  input  logic       rst,
  rv_muldiv_if.slave bus
);

  localparam int                CW       = $clog2(XLEN + 1);
  localparam int                PW       = XLEN + MUL_STEP;
  localparam logic [XLEN-1:0]   MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]     MUL_ITER = CW'(XLEN / MUL_STEP);
  localparam logic [CW-1:0]     DIV_ITER = CW'(XLEN);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [4:0]          tag_q, tag_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     mcand_q, mcand_d;
  logic [XLEN-1:0]     dvsr_q, dvsr_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [XLEN-1:0]     quo_q, quo_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     res_q, res_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [4:0]          rd_out_q, rd_out_d;
  logic                done_q, done_d;

  // ---------------------------------------------------------------- decode
  logic            w_rs1_neg, w_rs2_neg;
  logic [XLEN-1:0] w_rs1_mag, w_rs2_mag;
  logic            w_div_zero, w_div_ovf;

  assign w_rs1_neg  = f3_rs1_signed(bus.funct3) & bus.rs1_val[XLEN-1];
  assign w_rs2_neg  = f3_rs2_signed(bus.funct3) & bus.rs2_val[XLEN-1];
  // |MIN_NEG| wraps to MIN_NEG, which is the correct unsigned magnitude
  assign w_rs1_mag  = w_rs1_neg ? -bus.rs1_val : bus.rs1_val;
  assign w_rs2_mag  = w_rs2_neg ? -bus.rs2_val : bus.rs2_val;
  assign w_div_zero = (bus.rs2_val == '0);
  // Only the signed divide ops (funct3[0]==0) can overflow
  assign w_div_ovf  = ~bus.funct3[0] & (bus.rs1_val == MIN_NEG) & (bus.rs2_val == '1);

  // ------------------------------------------------------- multiply step
  // prod_q = {running high sum, unconsumed multiplier bits}; each cycle the
  // low MUL_STEP multiplier bits select a multiple of the multiplicand that
  // is added to the high half, then everything shifts right by MUL_STEP.
  logic [PW-1:0] w_partial;
  logic [PW-1:0] w_sum;

  assign w_partial = PW'(mcand_q) * PW'(prod_q[MUL_STEP-1:0]);
  assign w_sum     = PW'(prod_q[2*XLEN-1:XLEN]) + w_partial;

  // --------------------------------------------------------- divide step
  logic [XLEN-1:0] w_div_rem;
  logic            w_div_q;

  muldiv_div_step #(
    .XLEN (XLEN)
  ) u_div_step (
    .rem_i          (rem_q),
    .dividend_bit_i (quo_q[XLEN-1]),
    .divisor_i      (dvsr_q),
    .rem_o          (w_div_rem),
    .q_o            (w_div_q)
  );

  // ------------------------------------------------------------ sign fix
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;

  assign w_prod_fix = neg_q ? -prod_q : prod_q;
  assign w_quo_fix  = neg_q ? -quo_q  : quo_q;
  assign w_rem_fix  = neg_q ? -rem_q  : rem_q;

  // ------------------------------------------------- next state / datapath
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    tag_d    = tag_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    dvsr_d   = dvsr_q;
    prod_d   = prod_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    res_d    = res_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.kill) begin
          op_d    = bus.funct3;
          tag_d   = bus.rd_in;
          mcand_d = w_rs1_mag;
          dvsr_d  = w_rs2_mag;
          prod_d  = {{XLEN{1'b0}}, w_rs2_mag};
          quo_d   = w_rs1_mag;
          rem_d   = '0;
          if (bus.funct3[2]) begin
            // Remainder takes the dividend sign, quotient the XOR of signs
            neg_d = bus.funct3[1] ? w_rs1_neg : (w_rs1_neg ^ w_rs2_neg);
            cnt_d = DIV_ITER;
            if (w_div_zero) begin
              // Raw results loaded unsigned so FIX passes them through
              quo_d   = '1;
              rem_d   = bus.rs1_val;
              neg_d   = 1'b0;
              cnt_d   = '0;
              state_d = S_FIX;
            end else if (w_div_ovf) begin
              quo_d   = bus.rs1_val;
              rem_d   = '0;
              neg_d   = 1'b0;
              cnt_d   = '0;
              state_d = S_FIX;
            end else begin
              state_d = S_DIV;
            end
          end else begin
            neg_d   = w_rs1_neg ^ w_rs2_neg;
            cnt_d   = MUL_ITER;
            state_d = S_MUL;
          end
        end
      end

      S_MUL: begin
        if (bus.kill) begin
          state_d = S_IDLE;
        end else begin
          prod_d = {w_sum, prod_q[XLEN-1:MUL_STEP]};
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
      end

      S_DIV: begin
        if (bus.kill) begin
          state_d = S_IDLE;
        end else begin
          rem_d = w_div_rem;
          quo_d = {quo_q[XLEN-2:0], w_div_q};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (bus.kill) begin
          state_d = S_IDLE;
        end else begin
          case (op_q)
            F3_MUL:                       res_d = w_prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: res_d = w_prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              res_d = w_quo_fix;
            default:                      res_d = w_rem_fix;
          endcase
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // Outputs only change here so a kill earlier leaves result intact
        done_d   = 1'b1;
        result_d = res_q;
        rd_out_d = tag_q;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      tag_q    <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      dvsr_q   <= '0;
      prod_q   <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      res_q    <= '0;
      result_q <= '0;
      rd_out_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      dvsr_q   <= dvsr_d;
      prod_q   <= prod_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      res_q    <= res_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
      done_q   <= done_d;
    end
  end

  assign bus.ready  = (state_q == S_IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_muldiv
// Description : Directed self-checking bench for rv_muldiv. Two instances
//               (MUL_STEP=1 and MUL_STEP=4) receive identical stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic [4:0]  rd_in = '0;
  logic        kill = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv_muldiv_if #(.XLEN(32)) bus1 ();
  rv_muldiv_if #(.XLEN(32)) bus4 ();

  assign bus1.start = start;   assign bus4.start = start;
  assign bus1.funct3 = funct3; assign bus4.funct3 = funct3;
  assign bus1.rs1_val = rs1_val; assign bus4.rs1_val = rs1_val;
  assign bus1.rs2_val = rs2_val; assign bus4.rs2_val = rs2_val;
  assign bus1.rd_in = rd_in;   assign bus4.rd_in = rd_in;
  assign bus1.kill = kill;     assign bus4.kill = kill;

  rv_muldiv #(.XLEN(32), .MUL_STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  rv_muldiv #(.XLEN(32), .MUL_STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op to both instances and watch 40 cycles after the accepting
  // edge; latency is counted in edges from the accepting edge.
  task automatic do_op(input string tag, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp,
                       input int lat1, input int lat4);
    int got1, got4, dcnt1, rlow1;
    logic [31:0] r1, r4;
    logic [4:0]  t1, t4;
    got1 = -1; got4 = -1; dcnt1 = 0; rlow1 = 0;
    r1 = 'x; r4 = 'x; t1 = 'x; t4 = 'x;
    @(negedge clk);
    start = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0;
    if (!bus1.ready) rlow1++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (!bus1.ready) rlow1++;
      if (bus1.done) begin
        dcnt1++;
        if (got1 < 0) begin got1 = k; r1 = bus1.result; t1 = bus1.rd_out; end
      end
      if (bus4.done && got4 < 0) begin got4 = k; r4 = bus4.result; t4 = bus4.rd_out; end
    end
    chk({tag, ".lat1"},   32'(got1), 32'(lat1));
    chk({tag, ".lat4"},   32'(got4), 32'(lat4));
    chk({tag, ".res1"},   r1, exp);
    chk({tag, ".res4"},   r4, exp);
    chk({tag, ".rd1"},    32'(t1), 32'(rd));
    chk({tag, ".rd4"},    32'(t4), 32'(rd));
    chk({tag, ".pulse1"}, 32'(dcnt1), 32'd1);
    chk({tag, ".rdylo1"}, 32'(rlow1), 32'(lat1));
  endtask

  initial begin : stim
    int dcnt;

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("rst.ready1",  32'(bus1.ready), 32'd1);
    chk("rst.done1",   32'(bus1.done),  32'd0);
    chk("rst.result1", bus1.result,     32'd0);
    chk("rst.rdout1",  32'(bus1.rd_out), 32'd0);
    chk("rst.ready4",  32'(bus4.ready), 32'd1);
    chk("rst.result4", bus4.result,     32'd0);

    // Multiply: L = 34 for MUL_STEP=1, 10 for MUL_STEP=4
    do_op("mul7x6",  3'b000, 32'd7,        32'd6,        5'd5,  32'd42,        34, 10);
    do_op("mulh",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'h00000000,  34, 10);
    do_op("mulhu",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE,  34, 10);
    do_op("mulhsu",  3'b010, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF,  34, 10);
    do_op("mulneg",  3'b000, 32'hFFFFFFFD, 32'd5,        5'd4,  32'hFFFFFFF1,  34, 10);

    // Divide: L = 34 regardless of MUL_STEP
    do_op("div",     3'b100, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFD,  34, 34);
    do_op("rem",     3'b110, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFF,  34, 34);
    do_op("divu",    3'b101, 32'd100,      32'd7,        5'd8,  32'd14,        34, 34);
    do_op("remu",    3'b111, 32'd100,      32'd7,        5'd9,  32'd2,         34, 34);

    // Kill sampled at edge 10 of a DIV; result must stay at 2
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; rs1_val = 32'd1000; rs2_val = 32'd3; rd_in = 5'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill.ready1", 32'(bus1.ready), 32'd1);
    chk("kill.ready4", 32'(bus4.ready), 32'd1);
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus1.done || bus4.done) dcnt++;
    end
    chk("kill.nodone",  32'(dcnt),   32'd0);
    chk("kill.result1", bus1.result, 32'd2);
    chk("kill.result4", bus4.result, 32'd2);

    // start together with kill in IDLE is not accepted
    @(negedge clk);
    start = 1'b1; kill = 1'b1; funct3 = 3'b000; rs1_val = 32'd3; rs2_val = 32'd3; rd_in = 5'd11;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    chk("sk.ready1", 32'(bus1.ready), 32'd1);
    chk("sk.ready4", 32'(bus4.ready), 32'd1);
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus1.done || bus4.done) dcnt++;
    end
    chk("sk.nodone",  32'(dcnt),   32'd0);
    chk("sk.result1", bus1.result, 32'd2);

    // Special cases: L = 2
    do_op("divu0",   3'b101, 32'd5,        32'd0,        5'd12, 32'hFFFFFFFF,  2, 2);
    do_op("rem0",    3'b110, 32'd5,        32'd0,        5'd13, 32'd5,         2, 2);
    do_op("divovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000,  2, 2);
    do_op("removf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,         2, 2);

    // Reset in the middle of a MUL
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; rs1_val = 32'd9; rs2_val = 32'd9; rd_in = 5'd16;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst.ready1",  32'(bus1.ready), 32'd1);
    chk("mrst.done1",   32'(bus1.done),  32'd0);
    chk("mrst.result1", bus1.result,     32'd0);
    chk("mrst.ready4",  32'(bus4.ready), 32'd1);
    chk("mrst.result4", bus4.result,     32'd0);

    do_op("postrst", 3'b000, 32'd7,        32'd6,        5'd5,  32'd42,        34, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
